multicycle_control_unit: RTL and testbench

//  Multi-cycle FSM sequencing the CPU datapath: instruction fetch, register file

---
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU controller: a five-stage IF/ID/EXE/MEM/WB sequencer that also has an absorbing HALT state.
// Control outputs are combinational from the state, the opcode and the ALU Zero flag.
module multicycle_control_unit #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    Opcode,
  input  logic              Zero,
  input  logic              MemReady,
  output logic              PCWre,
  output logic [1:0]        PCSrc,
  output logic              IRWre,
  output logic              ExtSel,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              mRD,
  output logic              mWR,
  output logic              RegDst,
  output logic              DBDataSrc,
  output logic              RegWre,
  output logic              Halted,
  output logic [2:0]        State
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LW, C_SW, C_BR, C_J, C_HALT
  } iclass_t;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b011100);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100111);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_AND = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_SLL = ALUOPW'(3'b100);
  localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(3'b101);

  state_t              state_r;
  state_t              next_state_s;
  iclass_t             iclass_s;
  logic [ALUOPW-1:0]   alu_op_s;
  logic                src_a_s;
  logic                src_b_s;
  logic                ext_s;
  logic                rtype_s;
  logic                taken_s;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Opcode decode into an instruction class and the ALU-side controls
  always_comb begin
    iclass_s = C_NOP;
    alu_op_s = ALU_ADD;
    src_a_s  = 1'b0;
    src_b_s  = 1'b0;
    ext_s    = 1'b1;
    rtype_s  = 1'b0;
    taken_s  = 1'b0;
    case (Opcode)
      OP_ADD:   begin iclass_s = C_ALU; rtype_s = 1'b1; end
      OP_SUB:   begin iclass_s = C_ALU; rtype_s = 1'b1; alu_op_s = ALU_SUB; end
      OP_ADDIU: begin iclass_s = C_ALU; src_b_s = 1'b1; end
      OP_AND:   begin iclass_s = C_ALU; rtype_s = 1'b1; alu_op_s = ALU_AND; end
      OP_ANDI:  begin iclass_s = C_ALU; src_b_s = 1'b1; alu_op_s = ALU_AND; ext_s = 1'b0; end
      OP_ORI:   begin iclass_s = C_ALU; src_b_s = 1'b1; alu_op_s = ALU_OR;  ext_s = 1'b0; end
      OP_SLL:   begin iclass_s = C_ALU; rtype_s = 1'b1; src_a_s = 1'b1; alu_op_s = ALU_SLL; end
      OP_SLTI:  begin iclass_s = C_ALU; src_b_s = 1'b1; alu_op_s = ALU_SLT; end
      OP_SW:    begin iclass_s = C_SW;  src_b_s = 1'b1; end
      OP_LW:    begin iclass_s = C_LW;  src_b_s = 1'b1; end
      OP_BEQ:   begin iclass_s = C_BR;  alu_op_s = ALU_SUB; taken_s = Zero; end
      OP_BNE:   begin iclass_s = C_BR;  alu_op_s = ALU_SUB; taken_s = ~Zero; end
      OP_J:     begin iclass_s = C_J; end
      OP_HALT:  begin iclass_s = C_HALT; end
      default:  begin iclass_s = C_NOP; end
    endcase
  end

  // Next-state and strobe generation; Reset forces every output low
  always_comb begin
    next_state_s = state_r;
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegDst    = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    Halted    = 1'b0;
    State     = 3'b000;
    if (Reset) begin
      next_state_s = S_IF;
    end else begin
      State = state_r;
      // ALU controls stay valid from EXE through WB
      if (state_r == S_EXE || state_r == S_MEM || state_r == S_WB) begin
        ExtSel  = ext_s;
        ALUSrcA = src_a_s;
        ALUSrcB = src_b_s;
        ALUOp   = alu_op_s;
      end else begin
        ExtSel  = 1'b0;
      end
      case (state_r)
        S_IF: begin
          IRWre        = 1'b1;
          next_state_s = S_ID;
        end
        S_ID: begin
          case (iclass_s)
            C_J:     begin PCWre = 1'b1; PCSrc = 2'b11; next_state_s = S_IF; end
            C_HALT:  begin next_state_s = S_HALT; end
            C_NOP:   begin PCWre = 1'b1; next_state_s = S_IF; end
            default: begin next_state_s = S_EXE; end
          endcase
        end
        S_EXE: begin
          case (iclass_s)
            C_BR: begin
              PCWre        = 1'b1;
              PCSrc        = taken_s ? 2'b01 : 2'b00;
              next_state_s = S_IF;
            end
            C_LW, C_SW: next_state_s = S_MEM;
            default:    next_state_s = S_WB;
          endcase
        end
        S_MEM: begin
          mRD = (iclass_s == C_LW);
          mWR = (iclass_s == C_SW);
          if (!MemReady) begin
            next_state_s = S_MEM;
          end else if (iclass_s == C_LW) begin
            next_state_s = S_WB;
          end else begin
            PCWre        = 1'b1;
            next_state_s = S_IF;
          end
        end
        S_WB: begin
          RegWre       = 1'b1;
          RegDst       = rtype_s;
          DBDataSrc    = (iclass_s == C_LW);
          PCWre        = 1'b1;
          next_state_s = S_IF;
        end
        S_HALT: begin
          Halted       = 1'b1;
          next_state_s = S_HALT;
        end
        default: next_state_s = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected cycle traces are built from the opcode
// table and timing rules, then replayed against the controller one clock at a time.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       extsel;
    logic       srca;
    logic       srcb;
    logic [2:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       regdst;
    logic       dbsrc;
    logic       regwre;
    logic       halted;
    logic [2:0] state;
  } ctl_t;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, mRD, mWR, RegDst, DBDataSrc, RegWre, Halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp, State;

  int compared = 0;
  int mismatched = 0;

  ctl_t exp_q[$];
  logic rdy_q[$];

  multicycle_control_unit #(.OPW(6), .ALUOPW(3)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .RegDst(RegDst),
    .DBDataSrc(DBDataSrc), .RegWre(RegWre), .Halted(Halted), .State(State)
  );

  always #5 CLK = ~CLK;

  function automatic ctl_t observed();
    ctl_t o;
    o = '{PCWre, PCSrc, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, mRD, mWR,
          RegDst, DBDataSrc, RegWre, Halted, State};
    return o;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = observed();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction table as the reference sees it
  function automatic string kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
      6'b010010, 6'b011000, 6'b011100: return "alu";
      6'b100110: return "sw";
      6'b100111: return "lw";
      6'b110000, 6'b110001: return "br";
      6'b111000: return "j";
      6'b111111: return "halt";
      default:   return "nop";
    endcase
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110000, 6'b110001: return 3'b001;
      6'b010000, 6'b010001:            return 3'b010;
      6'b010010:                       return 3'b011;
      6'b011000:                       return 3'b100;
      6'b011100:                       return 3'b101;
      default:                         return 3'b000;
    endcase
  endfunction

  // Build the expected per-cycle trace of one instruction
  task automatic build(input logic [5:0] op, input logic z, input int waits);
    ctl_t c, a;
    string k;
    k = kind_of(op);
    exp_q.delete();
    rdy_q.delete();
    c = '0; c.irwre = 1'b1; c.state = 3'd0;
    exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
    c = '0; c.state = 3'd1;
    if (k == "j") begin c.pcwre = 1'b1; c.pcsrc = 2'b11; end
    if (k == "nop") c.pcwre = 1'b1;
    exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (k == "j" || k == "nop" || k == "halt") return;
    a = '0;
    a.aluop  = aluop_of(op);
    a.srca   = (op == 6'b011000);
    a.srcb   = (op inside {6'b000010, 6'b010001, 6'b010010, 6'b011100, 6'b100111, 6'b100110});
    a.extsel = !(op inside {6'b010001, 6'b010010});
    c = a; c.state = 3'd2;
    if (k == "br") begin
      c.pcwre = 1'b1;
      c.pcsrc = ((op == 6'b110000) ? z : !z) ? 2'b01 : 2'b00;
    end
    exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (k == "br") return;
    if (k == "lw" || k == "sw") begin
      for (int i = 0; i <= waits; i++) begin
        c = a; c.state = 3'd3;
        c.mrd = (k == "lw");
        c.mwr = (k == "sw");
        if (i == waits && k == "sw") c.pcwre = 1'b1;
        exp_q.push_back(c); rdy_q.push_back(i == waits);
      end
      if (k == "sw") return;
    end
    c = a; c.state = 3'd4;
    c.regwre = 1'b1; c.pcwre = 1'b1;
    c.regdst = (op inside {6'b000000, 6'b000001, 6'b010000, 6'b011000});
    c.dbsrc  = (k == "lw");
    exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Replay the trace; optionally replace the last cycle with a 2-cycle reset
  task automatic play(input string tag, input logic [5:0] op, input logic z, input logic abort);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      Opcode = op; Zero = z; MemReady = rdy_q[i];
      if (abort && i == n - 1) begin
        for (int r = 0; r < 2; r++) begin
          Reset = 1'b1;
          #1 check({tag, "_rst"}, '0);
          @(posedge CLK); #1;
        end
        Reset = 1'b0;
      end else begin
        #1 check(tag, exp_q[i]);
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic z, input int waits);
    build(op, z, waits);
    play(tag, op, z, 1'b0);
  endtask

  logic [5:0] pool [13] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                            6'b010010, 6'b011000, 6'b011100, 6'b100110, 6'b100111,
                            6'b110000, 6'b110001, 6'b111000};

  initial begin
    ctl_t c;
    logic [5:0] op;
    // Reset held: all outputs low
    Reset = 1'b1;
    @(posedge CLK); #1;
    check("reset0", '0);
    @(posedge CLK); #1;
    check("reset1", '0);
    Reset = 1'b0;

    // Reset during WB of add: RegWre must never rise, next cycle is IF
    build(6'b000000, 1'b0, 0);
    play("add_abort", 6'b000000, 1'b0, 1'b1);
    run("add", 6'b000000, 1'b0, 0);
    run("lw_wait3", 6'b100111, 1'b0, 3);
    run("sw_wait1", 6'b100110, 1'b1, 1);
    run("beq_taken", 6'b110000, 1'b1, 0);
    run("beq_not", 6'b110000, 1'b0, 0);
    run("bne_taken", 6'b110001, 1'b0, 0);
    run("j", 6'b111000, 1'b0, 0);
    run("nop_2a", 6'b101010, 1'b0, 0);

    // Random instruction mix, including unlisted opcodes
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (kind_of(op) != "nop");
      end else begin
        op = pool[$urandom_range(0, 12)];
      end
      run("rand", op, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Halt: absorbing regardless of opcode, only Reset leaves
    run("halt_fetch", 6'b111111, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      Opcode = 6'($urandom_range(0, 63)); Zero = 1'($urandom_range(0, 1));
      MemReady = 1'($urandom_range(0, 1));
      c = '0; c.halted = 1'b1; c.state = 3'd5;
      #1 check("halt", c);
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    #1 check("halt_reset", '0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    run("after_halt", 6'b000010, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
